// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. A single combinational full_adder cell is
// time-multiplexed to add two WIDTH-bit operands plus a carry-in, one bit per
// clock, LSB first. This block owns the operand shift registers, the carry
// flop, the bit counter and the start/busy/done handshake.
//
// Handshake: a request is accepted on any rising edge where start=1 and the
// FSM is in IDLE or DONE; a, b and cin are captured on that edge only. busy
// is high for the WIDTH cycles of computation, then done is high for exactly
// one cycle while sum/cout hold the new result. start seen while busy is
// dropped, not queued.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   request
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in
//   busy       out  high while computing (RUN)
//   done       out  one-cycle completion pulse (DONE)
//   sum        out  registered WIDTH-bit result
//   cout       out  registered carry-out of the MSB
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   dbg_r_sh   out  partial-result shift register
// -----------------------------------------------------------------------------

// One-bit full adder built from plain gates. This is the only adder logic in
// the design; the controller feeds it one bit per cycle.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic co
);
   logic ab_x;

   assign ab_x = a ^ b;
   assign sum  = ab_x ^ cin;
   assign co   = (a & b) | (ab_x & cin);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state,
   output logic [WIDTH-1:0] dbg_r_sh
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Counter value on the edge that computes the MSB.
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] r_sh_q, r_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_sum;
   logic             fa_co;
   logic [WIDTH-1:0] r_next;

   full_adder u_fa (
      .a   (a_sh_q[0]),
      .b   (b_sh_q[0]),
      .cin (carry_q),
      .sum (fa_sum),
      .co  (fa_co)
   );

   // New sum bit enters at the MSB while older bits move toward the LSB, so
   // after WIDTH shifts bit 0 of the result sits at bit 0 of the register.
   // A one-bit word has no older bits to keep.
   generate
      if (WIDTH == 1) begin : g_r_one
         assign r_next = fa_sum;
      end else begin : g_r_wide
         assign r_next = {fa_sum, r_sh_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      r_sh_d  = r_sh_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            r_sh_d  = r_next;
            carry_d = fa_co;
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // MSB computed this cycle: publish the full word.
               sum_d   = r_next;
               cout_d  = fa_co;
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         r_sh_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         r_sh_q  <= r_sh_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // All outputs come straight from flops.
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state_q;
   assign dbg_r_sh  = r_sh_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for serial_adder_ctrl: WIDTH=8 main instance with a cycle-level
// reference model checked every cycle, plus WIDTH=2 and WIDTH=1 instances.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT signals ----------------
   logic       start8 = 1'b0, cin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8, dbg_r_sh8;
   logic [1:0] dbg_state8;

   logic       start2 = 1'b0, cin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, cout2;
   logic [1:0] sum2, dbg_r_sh2;
   logic [1:0] dbg_state2;

   logic       start1 = 1'b0, cin1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1, dbg_r_sh1;
   logic [1:0] dbg_state1;

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
      .dbg_state(dbg_state8), .dbg_r_sh(dbg_r_sh8)
   );

   serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
      .dbg_state(dbg_state2), .dbg_r_sh(dbg_r_sh2)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
      .dbg_state(dbg_state1), .dbg_r_sh(dbg_r_sh1)
   );

   // ---------------- scoreboard counters ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int done8_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (WIDTH=8) ----------------
   // An accepted request makes the unit busy for 8 cycles; the arithmetic
   // sum a+b+cin then appears together with a one-cycle done.
   int         m_left = 0;
   logic       m_done = 1'b0;
   logic [7:0] m_sum  = '0;
   logic       m_cout = 1'b0;
   logic [8:0] m_res  = '0;
   logic [8:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
         exp_q.delete();
      end else if (m_left > 0) begin
         m_done = 1'b0;
         m_left--;
         if (m_left == 0) begin
            m_res = exp_q.pop_front();
            m_done = 1'b1;
            {m_cout, m_sum} = m_res;
         end
      end else begin
         m_done = 1'b0;
         if (start8) begin
            m_left = 8;
            exp_q.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      check("busy8", 32'(busy8), 32'(m_left > 0));
      check("done8", 32'(done8), 32'(m_done));
      check("sum8",  32'(sum8),  32'(m_sum));
      check("cout8", 32'(cout8), 32'(m_cout));
      check("busy_done_excl", 32'(busy8 & done8), 32'd0);
      if (done8 === 1'b1) done8_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Waits (bounded) for done of the selected instance; a timeout is a failure.
   task automatic wait_done(input int which, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         case (which)
            8:       seen = done8;
            2:       seen = done2;
            default: seen = done1;
         endcase
         if (seen) break;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL %s: no done within 30 cycles", name);
      end
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] exp_sum, input logic exp_cout, input string name);
      int t0;
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      tick();
      t0 = cyc;
      start8 = 1'b0;
      wait_done(8, name);
      check({name, "_latency"}, 32'(cyc - t0), 32'd8);
      check({name, "_sum"}, 32'(sum8), 32'(exp_sum));
      check({name, "_cout"}, 32'(cout8), 32'(exp_cout));
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base, t0, d1, d2;

      // Reset held 2 cycles with start asserted: nothing must start.
      rst = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      tick(); tick();
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum",  32'(sum8),  32'd0);
      rst = 1'b0; start8 = 1'b0;
      tick(); tick();
      check("post_rst_idle", 32'(busy8), 32'd0);

      // Single ops and carry chains.
      run8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "op_3c_0f");
      run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op_ff_01");
      run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_ff_ff");

      // Start while busy is dropped.
      base = done8_cnt;
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick();
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      wait_done(8, "ignore");
      check("ignore_sum",  32'(sum8),  32'h02);
      check("ignore_cout", 32'(cout8), 32'd0);
      repeat (12) tick();
      check("ignore_one_done", 32'(done8_cnt - base), 32'd1);

      // Reset at E0+4 aborts the operation.
      base = done8_cnt;
      a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_sum",  32'(sum8),  32'd0);
      check("abort_cout", 32'(cout8), 32'd0);
      rst = 1'b0;
      repeat (12) tick();
      check("abort_no_done", 32'(done8_cnt - base), 32'd0);

      // Back-to-back with start held high.
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      tick();
      t0 = cyc;
      a8 = 8'h7F; b8 = 8'h01;
      wait_done(8, "b2b_first");
      d1 = cyc;
      check("b2b_first_at", 32'(d1 - t0), 32'd8);
      check("b2b_first_sum",  32'(sum8),  32'h30);
      check("b2b_first_cout", 32'(cout8), 32'd0);
      tick();
      start8 = 1'b0;
      wait_done(8, "b2b_second");
      d2 = cyc;
      check("b2b_second_at", 32'(d2 - t0), 32'd17);
      check("b2b_second_sum",  32'(sum8),  32'h80);
      check("b2b_second_cout", 32'(cout8), 32'd0);
      tick(); tick();

      // WIDTH=2 exhaustive.
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         int exp;
         vv = 5'(v);
         a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0];
         exp = int'(a2) + int'(b2) + int'(cin2);
         start2 = 1'b1;
         tick();
         start2 = 1'b0;
         wait_done(2, "w2_done");
         check($sformatf("w2_%0d_%0d_%0d", a2, b2, cin2), 32'({cout2, sum2}), 32'(exp));
      end

      // WIDTH=1 smoke: 1+1+1.
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      tick();
      check("w1_done", 32'(done1), 32'd1);
      check("w1_sum",  32'(sum1),  32'd1);
      check("w1_cout", 32'(cout1), 32'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single gate-level `full_adder` cell to add two WIDTH-bit operands plus carry-in, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake, so the one-bit combinational adder can be reused for any word width. It sits between a requesting block that presents operands and the shared full-adder datapath.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request; sampled only when the FSM is in IDLE or DONE.
- `a`  input  WIDTH: operand A; captured on the accepting edge.
- `b`  input  WIDTH: operand B; captured on the accepting edge.
- `cin`  input  1: carry-in; captured on the accepting edge.
- `busy`  output  1: high while the FSM is in RUN.
- `done`  output  1: one-cycle pulse; high while the FSM is in DONE.
- `sum`  output  WIDTH: registered result, {cout,sum} = a + b + cin.
- `cout`  output  1: registered carry-out of the MSB.

## Operation
- Exactly one `full_adder` instance, in port order (a, b, cin, sum, co). Its inputs are the LSB of the A shift register, the LSB of the B shift register and the carry flip-flop. No other adder logic is permitted.
- FSM states: IDLE, RUN, DONE. Encoding is free.
  - IDLE: `start`=1 → RUN. Load A_sh←`a`, B_sh←`b`, carry←`cin`, count←0.
  - RUN, each edge:
    - R_sh ← {fa.sum, R_sh[WIDTH-1:1]}
    - carry ← fa.co
    - A_sh and B_sh shift right by 1
    - count ← count+1
    - When count = WIDTH-1 on this edge: `sum` ← {fa.sum, R_sh[WIDTH-1:1]}, `cout` ← fa.co, → DONE.
  - DONE: `start`=1 → RUN, with the same load as from IDLE (back-to-back operation). Otherwise → IDLE.
- `start` in RUN is ignored and is not queued.
- `a`, `b` and `cin` are don't-care except on the accepting edge.
- `sum`/`cout` change only on the completing edge and hold until the next completion or reset.
- Counter width is $clog2(WIDTH+1). WIDTH=1 completes in a single RUN cycle.
- Arithmetic is unsigned modulo 2^WIDTH. `cout` is the true carry, not signed overflow.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; all shift registers, carry and count = 0.
- `rst` dominates `start`. Reset mid-RUN aborts the operation: outputs return to reset values on that edge and no `done` pulse follows.
- Cycle timing, with start accepted at edge E0:
  - `busy`=1 from E0 to E0+WIDTH.
  - Bit i is computed in the cycle after edge E0+i.
  - Result is registered at E0+WIDTH.
  - `done`=1 for the single cycle following E0+WIDTH.
- Latency: WIDTH+1 edges from the accepting edge to `done` deasserting when no new start arrives.
- Throughput: one operation per WIDTH+1 cycles when `start` is held high.
- `busy` and `done` are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, reset: hold `rst` 2 cycles with `start`=1 → `busy`=0, `done`=0, `sum`=0x00, `cout`=0 throughout; no operation starts.
- WIDTH=8, single op: a=0x3C, b=0x0F, cin=1, `start` pulse at E0 → `busy` high for 8 cycles, `done` pulse after E0+8, `sum`=0x4C, `cout`=0.
- WIDTH=8, carry chain: a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. Then a=0xFF, b=0xFF, cin=1 → `sum`=0xFF, `cout`=1.
- WIDTH=8, ignore while busy: start 0x01+0x01 at E0, pulse `start` with a=0x80, b=0x80 at E0+3 → result 0x02/0; second request dropped, only one `done` pulse.
- WIDTH=8, abort and back-to-back:
  - `rst` at E0+4 mid-op → outputs zero, no `done`.
  - Then hold `start`=1 with 0x10+0x20 then 0x7F+0x01 → `done` pulses at E0'+8 and E0'+17, results 0x30/0 then 0x80/0.
- WIDTH=2, exhaustive: all 32 {a,b,cin} combinations → {cout,sum} == a+b+cin for every op; WIDTH=1 smoke test 1+1+1 → `sum`=1, `cout`=1 after 2 edges.
